// File: rtl/vs_mailbox_if.sv
// Pipelined Wishbone slave bundle for the vs_mailbox host side.
// The host drives the master modport; the mailbox takes the slave modport.
interface vs_mailbox_if;
  logic [2:0]  wbs_adr;
  logic [31:0] wbs_dat_w;
  logic [31:0] wbs_dat_r;
  logic [3:0]  wbs_sel;
  logic        wbs_cyc;
  logic        wbs_stb;
  logic        wbs_we;
  logic        wbs_ack;
  logic        wbs_stall;
  logic        wbs_err;

  modport master (
    output wbs_adr, wbs_dat_w, wbs_sel, wbs_cyc, wbs_stb, wbs_we,
    input  wbs_dat_r, wbs_ack, wbs_stall, wbs_err
  );

  modport slave (
    input  wbs_adr, wbs_dat_w, wbs_sel, wbs_cyc, wbs_stb, wbs_we,
    output wbs_dat_r, wbs_ack, wbs_stall, wbs_err
  );
endinterface

// File: rtl/vs_mailbox.sv
// Bidirectional host/core mailbox: H2C and C2H FIFOs, sticky W1C IRQ status, doorbell and
// core reset control. Host side is a pipelined Wishbone slave, core side a strobed IO bus.
module vs_mailbox #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned C2H_THRESH = 1,
  parameter logic [31:0] SIGNATURE  = 32'h4d424f58
) (
  input  logic        i_sys_clk,
  input  logic        i_rst,
  vs_mailbox_if.slave wb,
  input  logic [15:0] i_core_addr,
  input  logic        i_core_rd,
  input  logic        i_core_wr,
  input  logic [31:0] i_core_dout,
  output logic [31:0] o_core_din,
  output logic        o_core_rst_n,
  output logic        o_core_irq,
  output logic        o_irq_out
);
  localparam int unsigned   AW        = $clog2(DEPTH);
  localparam int unsigned   LW        = AW + 1;
  localparam logic [LW-1:0] FULL_L    = LW'(DEPTH);
  localparam logic [LW-1:0] THRESH_L  = LW'(C2H_THRESH);
  localparam logic [LW-1:0] ONE_L     = LW'(1);
  localparam logic [15:0]   CORE_FIFO = 16'h1000;
  localparam logic [15:0]   CORE_BELL = 16'h1004;
  localparam logic [15:0]   CORE_STAT = 16'h2000;

  logic [DATA_W-1:0] r_h2c_mem [DEPTH];
  logic [DATA_W-1:0] r_c2h_mem [DEPTH];
  logic [LW-1:0]     r_h2c_wr, r_h2c_rd, r_c2h_wr, r_c2h_rd;
  logic [LW-1:0]     w_h2c_wr_d, w_h2c_rd_d, w_c2h_wr_d, w_c2h_rd_d;
  logic [LW-1:0]     w_h2c_level, w_c2h_level, w_h2c_level_d, w_c2h_level_d;
  logic              w_h2c_empty, w_h2c_full, w_c2h_empty, w_c2h_full;
  logic [4:0]        r_status, r_enable, w_status_d, w_set, w_w1c;
  logic              r_run, r_ack, r_irq;
  logic [31:0]       r_dat_r, r_core_din, w_rd_data, w_core_din;
  logic              w_req, w_wr, w_rd, w_ctrl_wr, w_flush_h2c, w_flush_c2h;
  logic              w_host_push, w_host_pop, w_core_pop, w_core_push;
  logic              w_h2c_push, w_h2c_pop, w_c2h_push, w_c2h_pop;
  logic              w_unused_sel;

  assign w_req       = wb.wbs_cyc & wb.wbs_stb;
  assign w_wr        = w_req & wb.wbs_we;
  assign w_rd        = w_req & ~wb.wbs_we;
  assign w_ctrl_wr   = w_wr && (wb.wbs_adr == 3'd2);
  assign w_flush_h2c = w_ctrl_wr & wb.wbs_dat_w[1];
  assign w_flush_c2h = w_ctrl_wr & wb.wbs_dat_w[2];
  assign w_host_push = w_wr && (wb.wbs_adr == 3'd3);
  assign w_host_pop  = w_rd && (wb.wbs_adr == 3'd4);
  assign w_core_pop  = i_core_rd && (i_core_addr == CORE_FIFO);
  assign w_core_push = i_core_wr && (i_core_addr == CORE_FIFO);
  assign w_unused_sel = ^wb.wbs_sel;

  assign w_h2c_level = r_h2c_wr - r_h2c_rd;
  assign w_c2h_level = r_c2h_wr - r_c2h_rd;
  assign w_h2c_empty = (w_h2c_level == '0);
  assign w_c2h_empty = (w_c2h_level == '0);
  assign w_h2c_full  = (w_h2c_level == FULL_L);
  assign w_c2h_full  = (w_c2h_level == FULL_L);

  // A same-cycle pop frees the slot, so a push into a full FIFO is accepted alongside it.
  assign w_h2c_pop  = w_core_pop & ~w_h2c_empty;
  assign w_h2c_push = w_host_push & (~w_h2c_full | w_h2c_pop);
  assign w_c2h_pop  = w_host_pop & ~w_c2h_empty;
  assign w_c2h_push = w_core_push & (~w_c2h_full | w_c2h_pop);

  always_comb begin
    w_h2c_wr_d = r_h2c_wr;
    w_h2c_rd_d = r_h2c_rd;
    w_c2h_wr_d = r_c2h_wr;
    w_c2h_rd_d = r_c2h_rd;
    if (w_h2c_push) w_h2c_wr_d = r_h2c_wr + ONE_L;
    if (w_h2c_pop)  w_h2c_rd_d = r_h2c_rd + ONE_L;
    if (w_c2h_push) w_c2h_wr_d = r_c2h_wr + ONE_L;
    if (w_c2h_pop)  w_c2h_rd_d = r_c2h_rd + ONE_L;
    if (w_flush_h2c) begin
      w_h2c_wr_d = r_h2c_wr;
      w_h2c_rd_d = r_h2c_wr;
    end
    if (w_flush_c2h) begin
      w_c2h_wr_d = r_c2h_wr;
      w_c2h_rd_d = r_c2h_wr;
    end
  end

  assign w_h2c_level_d = w_h2c_wr_d - w_h2c_rd_d;
  assign w_c2h_level_d = w_c2h_wr_d - w_c2h_rd_d;

  assign w_set[0] = (w_c2h_level < THRESH_L) && (w_c2h_level_d >= THRESH_L);
  assign w_set[1] = ~w_flush_h2c && (w_h2c_level == ONE_L) && (w_h2c_level_d == '0);
  assign w_set[2] = w_host_push & w_h2c_full & ~w_h2c_pop;
  assign w_set[3] = w_host_pop & w_c2h_empty;
  assign w_set[4] = i_core_wr && (i_core_addr == CORE_BELL);
  assign w_w1c    = (w_wr && (wb.wbs_adr == 3'd0)) ? wb.wbs_dat_w[4:0] : 5'b0;
  // New events take priority over a same-cycle clear.
  assign w_status_d = (r_status & ~w_w1c) | w_set;

  always_comb begin
    w_rd_data = '0;
    case (wb.wbs_adr)
      3'd0: w_rd_data = {27'b0, r_status};
      3'd1: w_rd_data = {27'b0, r_enable};
      3'd2: w_rd_data = {31'b0, r_run};
      3'd4: if (!w_c2h_empty) w_rd_data = 32'(r_c2h_mem[r_c2h_rd[AW-1:0]]);
      3'd5: w_rd_data = {8'b0, 8'(w_c2h_level), 8'(w_h2c_level), 4'b0,
                         w_c2h_full, w_c2h_empty, w_h2c_full, w_h2c_empty};
      3'd6: w_rd_data = SIGNATURE;
      default: ;
    endcase
  end

  always_comb begin
    w_core_din = '0;
    case (i_core_addr)
      CORE_FIFO: if (!w_h2c_empty) w_core_din = 32'(r_h2c_mem[r_h2c_rd[AW-1:0]]);
      CORE_STAT: w_core_din = {30'b0, w_c2h_full, ~w_h2c_empty};
      default: ;
    endcase
  end

  always_ff @(posedge i_sys_clk) begin
    if (w_h2c_push) r_h2c_mem[r_h2c_wr[AW-1:0]] <= wb.wbs_dat_w[DATA_W-1:0];
    if (w_c2h_push) r_c2h_mem[r_c2h_wr[AW-1:0]] <= i_core_dout[DATA_W-1:0];
  end

  always_ff @(posedge i_sys_clk or posedge i_rst) begin
    if (i_rst) begin
      r_h2c_wr   <= '0;
      r_h2c_rd   <= '0;
      r_c2h_wr   <= '0;
      r_c2h_rd   <= '0;
      r_status   <= '0;
      r_enable   <= '0;
      r_run      <= 1'b0;
      r_ack      <= 1'b0;
      r_dat_r    <= '0;
      r_core_din <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_h2c_wr   <= w_h2c_wr_d;
      r_h2c_rd   <= w_h2c_rd_d;
      r_c2h_wr   <= w_c2h_wr_d;
      r_c2h_rd   <= w_c2h_rd_d;
      r_status   <= w_status_d;
      if (w_wr && (wb.wbs_adr == 3'd1)) r_enable <= wb.wbs_dat_w[4:0];
      if (w_ctrl_wr) r_run <= wb.wbs_dat_w[0];
      r_ack      <= w_req;
      r_dat_r    <= w_rd ? w_rd_data : 32'b0;
      r_core_din <= w_core_din;
      r_irq      <= |(r_status & r_enable);
    end
  end

  assign wb.wbs_ack   = r_ack & wb.wbs_cyc;
  assign wb.wbs_dat_r = r_dat_r;
  assign wb.wbs_stall = 1'b0;
  assign wb.wbs_err   = 1'b0;
  assign o_core_din   = r_core_din;
  assign o_core_rst_n = r_run;
  assign o_core_irq   = ~w_h2c_empty;
  assign o_irq_out    = r_irq;
endmodule
